// File: rtl/switch_scan_ctrl_pkg.sv
// rtl/switch_scan_ctrl_pkg.sv - register offsets, FSM states and defaults for switch_scan_ctrl
package switch_scan_ctrl_pkg;

  localparam logic [1:0] SW_LO     = 2'd0;
  localparam logic [1:0] SW_HI     = 2'd1;
  localparam logic [1:0] SW_STATUS = 2'd2;
  localparam logic [1:0] SW_CTRL   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [19:0] DEF_DEBOUNCE_CYCLES = 20'd500000;

endpackage

// File: rtl/switch_sync.sv
// rtl/switch_sync.sv - two-flop synchroniser, resets to all-ones (raw idle level of the pins)
module switch_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= '1;
      q  <= '1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/switch_scan_ctrl.sv
// rtl/switch_scan_ctrl.sv - DIP switch debounce, change-detect and register interface
// Optional macro SWITCH_IRQ_EN adds the irq_en control bit and the irq output.
module switch_scan_ctrl
  import switch_scan_ctrl_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int          CNT_W           = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] dip_raw,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 20'd1);

  state_t             state;
  logic [63:0]        sync_raw;
  logic [63:0]        sync_q;
  logic [63:0]        cand;
  logic [63:0]        stable;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         chg;
  logic [1:0]         chg_set;
  logic [1:0]         chg_clr;
  logic               freeze;
  logic               irq_en_bit;
  logic               busy;
  logic               unused_wdata;

  switch_sync #(.W(64)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (dip_raw),
    .q       (sync_raw)
  );

  assign sync_q       = ~sync_raw;
  assign busy         = (state != ST_IDLE);
  assign unused_wdata = ^wdata;

  assign chg_set = (state == ST_COMMIT) ?
                   {cand[63:32] != stable[63:32], cand[31:0] != stable[31:0]} : 2'b00;
  assign chg_clr = (we && addr == SW_STATUS) ? wdata[1:0] : 2'b00;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cand   <= '0;
      stable <= '0;
      cnt    <= '0;
      chg    <= '0;
      freeze <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sync_q != stable && !freeze) begin
            cand  <= sync_q;
            cnt   <= '0;
            state <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          // Any movement restarts the settle window; cnt stops at CNT_LAST.
          if (sync_q != cand) begin
            cand <= sync_q;
            cnt  <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_COMMIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_COMMIT: begin
          stable <= cand;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      // Set applied after clear so a commit beats a same-cycle W1C.
      chg <= (chg & ~chg_clr) | chg_set;
      if (we && addr == SW_CTRL) freeze <= wdata[1];
    end
  end

`ifdef SWITCH_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (we && addr == SW_CTRL) irq_en <= wdata[0];
      irq <= irq_en & (|chg);
    end
  end

  assign irq_en_bit = irq_en;
`else
  assign irq_en_bit = 1'b0;
  assign irq        = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (addr)
      SW_LO:     rdata = stable[31:0];
      SW_HI:     rdata = stable[63:32];
      SW_STATUS: rdata = {29'b0, busy, chg};
      SW_CTRL:   rdata = {30'b0, freeze, irq_en_bit};
      default:   rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_switch_scan_ctrl.sv
// tb/tb_switch_scan_ctrl.sv - scoreboard bench for switch_scan_ctrl with DEBOUNCE_CYCLES=4
module tb_switch_scan_ctrl;

`ifdef SWITCH_IRQ_EN
  localparam logic IRQB = 1'b1;
`else
  localparam logic IRQB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] dip_raw = '1;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  exp_t q[$];
  logic mon_req = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  switch_scan_ctrl #(.DEBOUNCE_CYCLES(20'd4), .CNT_W(20)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .dip_raw (dip_raw),
    .addr    (addr),
    .we      (we),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, got no summary, require completion");
    $fatal(1);
  end

  // Monitor: compares each presented read against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_req) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard_empty: got read with no expectation");
        end else begin
          e = q.pop_front();
          if (rdata !== e.rd) begin
            n_bad++;
            $display("FAIL %s rdata: got %h, require %h", e.name, rdata, e.rd);
          end
          n_cmp++;
          if (irq !== e.irq) begin
            n_bad++;
            $display("FAIL %s irq: got %b, require %b", e.name, irq, e.irq);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp_rd,
                    input logic exp_irq);
    exp_t e;
    e.name = name;
    e.rd   = exp_rd;
    e.irq  = exp_irq;
    q.push_back(e);
    addr    = a;
    mon_req = 1'b1;
    @(posedge clk);
    #1;
    mon_req = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we    = 1'b0;
    wdata = '0;
  endtask

  initial begin
    // Reset with pins idle
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    rd("rst_lo", 2'd0, 32'h0, 1'b0);
    rd("rst_hi", 2'd1, 32'h0, 1'b0);
    rd("rst_status", 2'd2, 32'h0, 1'b0);
    rd("rst_ctrl", 2'd3, 32'h0, 1'b0);

    // Switch 0 on: commit exactly at edge 8, irq one edge later
    wr(2'd3, 32'h1);
    dip_raw[7:0] = 8'hFE;
    tick(7);
    rd("lo_before_commit", 2'd0, 32'h0, 1'b0);
    rd("lo_at_commit", 2'd0, 32'h1, 1'b0);
    rd("status_after_lo", 2'd2, 32'h1, IRQB);
    rd("ctrl_irq_en", 2'd3, {31'b0, IRQB}, IRQB);

    // W1C of chg[0]; irq falls one edge after chg
    wr(2'd2, 32'h1);
    rd("status_cleared", 2'd2, 32'h0, IRQB);
    rd("irq_dropped", 2'd2, 32'h0, 1'b0);

    // 3-cycle glitch on bit 40 never commits
    dip_raw[40] = 1'b0;
    tick(3);
    dip_raw[40] = 1'b1;
    rd("glitch_busy", 2'd2, 32'h4, 1'b0);
    tick(7);
    rd("glitch_hi", 2'd1, 32'h0, 1'b0);
    rd("glitch_status", 2'd2, 32'h0, 1'b0);
    rd("glitch_lo", 2'd0, 32'h1, 1'b0);

    // W1C on the commit edge setting chg[1]: set wins
    dip_raw[32] = 1'b0;
    tick(7);
    wr(2'd2, 32'h3);
    rd("set_wins", 2'd2, 32'h2, 1'b0);
    rd("set_wins_irq", 2'd2, 32'h2, IRQB);
    wr(2'd2, 32'h2);
    rd("second_clear", 2'd2, 32'h0, IRQB);
    rd("second_clear_irq", 2'd1, 32'h1, 1'b0);

    // Freeze holds off new changes until released
    wr(2'd3, 32'h3);
    rd("ctrl_frozen", 2'd3, {30'b0, 1'b1, IRQB}, 1'b0);
    dip_raw[63:56] = 8'h00;
    tick(12);
    rd("frozen_hi", 2'd1, 32'h1, 1'b0);
    rd("frozen_idle", 2'd2, 32'h0, 1'b0);
    wr(2'd3, 32'h1);
    tick(5);
    rd("unfreeze_before", 2'd1, 32'h1, 1'b0);
    rd("unfreeze_commit", 2'd1, 32'hFF00_0001, 1'b0);
    rd("unfreeze_status", 2'd2, 32'h2, IRQB);

    // Reset during COUNT: everything cleared, nothing commits
    dip_raw[15:8] = 8'h00;
    tick(4);
    reset_n = 1'b0;
    dip_raw = '1;
    tick(1);
    reset_n = 1'b1;
    rd("midrst_lo", 2'd0, 32'h0, 1'b0);
    rd("midrst_status", 2'd2, 32'h0, 1'b0);
    rd("midrst_ctrl", 2'd3, 32'h0, 1'b0);
    tick(10);
    rd("midrst_hi_later", 2'd1, 32'h0, 1'b0);
    rd("midrst_lo_later", 2'd0, 32'h0, 1'b0);
    rd("midrst_status_later", 2'd2, 32'h0, 1'b0);

    tick(2);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, require 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/switch_scan_ctrl.md
Name: switch_scan_ctrl

Overview:
Debounce and change-detect controller for the 64-bit DIP switch bank on the bridge bus. It synchronises the raw active-low switch pins, filters bounce with a shared settle counter, and holds a committed, inverted "stable" snapshot for CPU reads. It flags per-word changes and raises an interrupt to the CP0 interrupt input.

Parameters:
DEBOUNCE_CYCLES, 20'd500000, consecutive equal-sample cycles required before commit; must be >= 1
CNT_W, 20, settle counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
dip_raw  in  64  raw switch pins, {sw7..sw0}, active-low
addr  in  2  word select: 0 SW_LO, 1 SW_HI, 2 STATUS, 3 CTRL
we  in  1  bus write strobe, one cycle
wdata  in  32  bus write data
rdata  out  32  combinational read of the register selected by addr
irq  out  1  level interrupt to CP0

Behaviour:
- Sync stage: two flops on dip_raw, then inversion. sync_q is the inverted, twice-registered value.
- FSM states: IDLE, COUNT, COMMIT. Registers: cand[63:0], stable[63:0], cnt[CNT_W-1:0], chg[1:0], irq_en, freeze.
- IDLE: if sync_q != stable and freeze==0 -> cand<=sync_q, cnt<=0, go COUNT. Otherwise stay.
- COUNT: if sync_q != cand -> cand<=sync_q, cnt<=0, stay. Else if cnt==DEBOUNCE_CYCLES-1 -> go COMMIT. Else cnt<=cnt+1.
- COMMIT: stable<=cand. chg[0] |= (cand[31:0]!=stable[31:0]). chg[1] |= (cand[63:32]!=stable[63:32]). Go IDLE.
- Latency: a raw change held constant is captured into cand at edge 3 and committed at edge DEBOUNCE_CYCLES+4.
- A glitch shorter than DEBOUNCE_CYCLES never reaches stable.
- If the input bounces back to the stable value during COUNT: commit proceeds, the stable value is unchanged, and chg is not set.
- freeze: IDLE ignores changes. A COUNT/COMMIT already in progress completes.
- Register map (rdata):
  - 0 = stable[31:0]
  - 1 = stable[63:32]
  - 2 = {29'b0, busy, chg[1:0]}, where busy = (state!=IDLE)
  - 3 = {30'b0, freeze, irq_en}
- Writes:
  - addr 2 is write-1-to-clear on chg[1:0].
  - addr 3 loads freeze and irq_en from wdata[1:0].
  - Writes to addr 0/1 are ignored.
- Simultaneous COMMIT set and W1C clear on the same chg bit: the set wins.
- irq = irq_en & |chg, registered; it asserts the cycle after chg becomes nonzero.
- Reset (any state, mid-count included):
  - state=IDLE; cnt, cand, chg, irq_en, freeze, irq = 0.
  - stable = 64'h0, so switches read as all-off.
  - Sync flops reset to all-ones, which is the raw idle level.
- cnt never wraps; it saturates by construction at DEBOUNCE_CYCLES-1.

Optional Feature:
SWITCH_IRQ_EN
- Defined: irq_en register, irq output and CTRL bit0 behave as above.
- Undefined: no irq_en flop; CTRL bit0 reads 0 and ignores writes; irq is tied 0. chg and STATUS still work for polling.

Decomposition:
- def.v holds:
  - register offsets SW_LO/SW_HI/SW_STATUS/SW_CTRL
  - FSM state encodings (2 bits)
  - default DEBOUNCE_CYCLES
- One sub-module, switch_sync: parameterised-width two-flop synchroniser with reset-to-ones, instantiated at width 64.

Test Plan:
- Reset, then idle pins all 1 -> rdata at addr 0/1 = 0, STATUS = 0, irq = 0.
- DEBOUNCE_CYCLES=4, irq_en=1; dip_raw[7:0] 8'hFF->8'hFE held -> addr0 reads 32'h1 at edge 8 after the change; STATUS=3'b001; irq=1 one cycle later.
- DEBOUNCE_CYCLES=4; 3-cycle low pulse on dip_raw[40] -> stable unchanged, chg=0, busy seen high then low.
- Write addr2 wdata=3 in the same cycle as a COMMIT setting chg[1] -> chg[1] remains 1; a second write clears it and irq drops next cycle.
- freeze=1, then toggle dip_raw[63:56] to 8'h00 -> SW_HI unchanged. Write freeze=0 -> SW_HI = 32'hFF000000 after DEBOUNCE_CYCLES+2 cycles.
- Assert reset_n=0 during COUNT -> next cycle state IDLE, all registers 0, irq 0; no commit occurs.
